// File: rtl/hs_core_pkg.sv
// Shared definitions for ap_ctrl-style arithmetic cores: one-hot FSM states,
// working_key bit positions and the handshake signal ordering.
package hs_core_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_ITER = 3'b010,
        ST_DONE = 3'b100
    } state_t;

    localparam int unsigned KEY_NOCLR = 3;
    localparam int unsigned KEY_HALF  = 4;
    localparam int unsigned KEY_DROP  = 5;

    // Canonical bit order when ap_ctrl handshake signals are bundled.
    typedef struct packed {
        logic start;
        logic done;
        logic idle;
        logic ready;
    } ap_ctrl_t;

endpackage

// File: rtl/hs_seq_mul64_mul_step.sv
// One shift-add multiply iteration: conditionally accumulate the multiplicand,
// then advance multiplicand left and multiplier right.
module mul_step
    import hs_core_pkg::*;
#(
    parameter int unsigned WIDTH = 64
) (
    input  logic [WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0] mcand_i,
    input  logic [WIDTH-1:0] mplier_i,
    output logic [WIDTH-1:0] acc_o,
    output logic [WIDTH-1:0] mcand_o,
    output logic [WIDTH-1:0] mplier_o
);

    always_comb begin
        acc_o    = acc_i + (mplier_i[0] ? mcand_i : '0);
        mcand_o  = mcand_i << 1;
        mplier_o = mplier_i >> 1;
    end

endmodule

// File: rtl/hs_seq_mul64.sv
// Iterative unsigned shift-add multiplier behind an ap_start/ap_done/ap_idle/ap_ready
// handshake; returns the low WIDTH bits of a*b with fixed latency.
module hs_seq_mul64
    import hs_core_pkg::*;
#(
    parameter  int unsigned WIDTH = 64,
    localparam int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic             ap_clk,
    input  logic             ap_rst,
    input  logic             ap_start,
    output logic             ap_done,
    output logic             ap_idle,
    output logic             ap_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] ap_return,
    input  logic [31:0]      working_key
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] ret_q, ret_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [WIDTH-1:0] step_acc, step_mcand, step_mplier;
    logic [CNT_W-1:0] last_cnt;
    logic             unused_key_bits;

    assign unused_key_bits = ^{working_key[31:6], working_key[2:0]};

    mul_step #(.WIDTH(WIDTH)) u_step (
        .acc_i    (acc_q),
        .mcand_i  (mcand_q),
        .mplier_i (mplier_q),
        .acc_o    (step_acc),
        .mcand_o  (step_mcand),
        .mplier_o (step_mplier)
    );

    assign last_cnt  = working_key[KEY_HALF] ? CNT_W'(WIDTH / 2 - 1) : CNT_W'(WIDTH - 1);
    assign ap_done   = (state_q == ST_DONE);
    assign ap_ready  = ap_done;
    assign ap_idle   = (state_q == ST_IDLE) & ~ap_start;
    assign ap_return = ret_q;

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        ret_d    = ret_q;
        case (state_q)
            ST_IDLE: begin
                if (ap_start) begin
                    mcand_d  = a;
                    mplier_d = b;
                    cnt_d    = '0;
                    if (!working_key[KEY_NOCLR]) acc_d = '0;
                    state_d  = ST_ITER;
                end
            end
            ST_ITER: begin
                acc_d    = step_acc;
                mcand_d  = step_mcand;
                mplier_d = step_mplier;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == last_cnt) begin
                    // Drop mode returns the accumulator before the final addend.
                    ret_d   = working_key[KEY_DROP] ? acc_q : step_acc;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q  <= ST_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            ret_q    <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            ret_q    <= ret_d;
        end
    end

endmodule

// File: tb/tb_hs_seq_mul64.sv
// Directed self-checking bench for hs_seq_mul64 (WIDTH=64).
module tb_hs_seq_mul64;

    logic        ap_clk = 1'b0;
    logic        ap_rst = 1'b1;
    logic        ap_start = 1'b0;
    logic        ap_done, ap_idle, ap_ready;
    logic [63:0] a = '0;
    logic [63:0] b = '0;
    logic [63:0] ap_return;
    logic [31:0] working_key = '0;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int done_cnt = 0;

    hs_seq_mul64 #(.WIDTH(64)) dut (
        .ap_clk      (ap_clk),
        .ap_rst      (ap_rst),
        .ap_start    (ap_start),
        .ap_done     (ap_done),
        .ap_idle     (ap_idle),
        .ap_ready    (ap_ready),
        .a           (a),
        .b           (b),
        .ap_return   (ap_return),
        .working_key (working_key)
    );

    always #5 ap_clk = ~ap_clk;

    always @(posedge ap_clk) cyc <= cyc + 1;

    always @(posedge ap_clk) begin
        #2;
        if (ap_done) done_cnt = done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!ap_done && n < 200) begin
            @(negedge ap_clk);
            n++;
        end
        chk({tag, "_done"}, {63'd0, ap_done}, 64'd1);
        chk({tag, "_ready"}, {63'd0, ap_ready}, 64'd1);
    endtask

    task automatic run_op(input string tag, input logic [63:0] av, input logic [63:0] bv,
                          input logic [31:0] kv, input int exp_lat, input logic [63:0] exp_res);
        int t0;
        @(negedge ap_clk);
        a = av; b = bv; working_key = kv; ap_start = 1'b1;
        t0 = cyc;
        @(negedge ap_clk);
        ap_start = 1'b0;
        wait_done(tag);
        chk({tag, "_lat"}, 64'(cyc - t0), 64'(exp_lat));
        chk({tag, "_ret"}, ap_return, exp_res);
    endtask

    initial begin
        int t0, d1, dc0;

        repeat (2) @(negedge ap_clk);
        chk("rst_done", {63'd0, ap_done}, 64'd0);
        chk("rst_ready", {63'd0, ap_ready}, 64'd0);
        chk("rst_ret", ap_return, 64'd0);
        ap_rst = 1'b0;
        @(negedge ap_clk);
        chk("idle_pre", {63'd0, ap_idle}, 64'd1);

        run_op("basic", 64'd3, 64'd5, 32'h0, 65, 64'd15);
        @(negedge ap_clk);
        chk("idle_post", {63'd0, ap_idle}, 64'd1);

        run_op("ovf1", 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 32'h0, 65, 64'hFFFF_FFFF_FFFF_FFFE);
        run_op("ovf2", 64'h1_0000_0000, 64'h1_0000_0000, 32'h0, 65, 64'd0);
        run_op("mix", 64'h0123_4567_89AB_CDEF, 64'd3, 32'h0, 65, 64'h0369_D036_9D03_69CD);

        // Back-to-back with ap_start held through DONE.
        @(negedge ap_clk);
        a = 64'd7; b = 64'd6; working_key = '0; ap_start = 1'b1;
        t0 = cyc;
        wait_done("b2b1");
        chk("b2b1_lat", 64'(cyc - t0), 64'd65);
        chk("b2b1_ret", ap_return, 64'd42);
        d1 = cyc;
        a = 64'd9; b = 64'd9;
        @(negedge ap_clk);
        chk("b2b_idle", {63'd0, ap_idle}, 64'd0);
        @(negedge ap_clk);
        ap_start = 1'b0;
        wait_done("b2b2");
        chk("b2b_gap", 64'(cyc - d1), 64'd66);
        chk("b2b2_ret", ap_return, 64'd81);

        // Start pulse and operand churn during ITER are ignored.
        @(negedge ap_clk);
        a = 64'd10; b = 64'd20; ap_start = 1'b1;
        t0 = cyc;
        @(negedge ap_clk);
        ap_start = 1'b0;
        dc0 = done_cnt;
        repeat (5) @(negedge ap_clk);
        for (int i = 0; i < 10; i++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            ap_start = (i == 3);
            @(negedge ap_clk);
        end
        ap_start = 1'b0;
        wait_done("ign");
        chk("ign_lat", 64'(cyc - t0), 64'd65);
        chk("ign_ret", ap_return, 64'd200);
        repeat (80) @(negedge ap_clk);
        chk("ign_once", 64'(done_cnt - dc0), 64'd1);
        chk("ign_hold", ap_return, 64'd200);

        // Reset in the middle of an operation.
        @(negedge ap_clk);
        a = 64'd5; b = 64'd5; ap_start = 1'b1;
        t0 = cyc;
        @(negedge ap_clk);
        ap_start = 1'b0;
        dc0 = done_cnt;
        while (cyc < t0 + 30) @(negedge ap_clk);
        ap_rst = 1'b1;
        @(negedge ap_clk);
        ap_rst = 1'b0;
        chk("mid_rst_ret", ap_return, 64'd0);
        chk("mid_rst_idle", {63'd0, ap_idle}, 64'd1);
        repeat (100) @(negedge ap_clk);
        chk("mid_rst_nodone", 64'(done_cnt - dc0), 64'd0);
        run_op("post_rst", 64'd4, 64'd4, 32'h0, 65, 64'd16);

        // Key lock behaviour.
        run_op("half_hi", 64'd1, 64'h100_0000_0000, 32'h10, 33, 64'd0);
        run_op("half_lo", 64'd3, 64'd5, 32'h10, 33, 64'd15);
        run_op("drop_top", 64'd1, 64'h8000_0000_0000_0000, 32'h20, 65, 64'd0);
        run_op("drop_low", 64'd3, 64'd4, 32'h20, 65, 64'd12);
        run_op("noclr_pre", 64'd2, 64'd3, 32'h0, 65, 64'd6);
        run_op("noclr", 64'd1, 64'd1, 32'h8, 65, 64'd7);
        run_op("key_other", 64'd11, 64'd13, 32'hFFFF_FFC7, 65, 64'd143);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
